// File: rtl/async_fifo.sv
// Single-clock byte FIFO with registered read data (1-cycle read latency) and full/empty status.
// Writes are ignored while full and reads are ignored while empty; out holds its last read value.
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  mem_full,
    output logic                  mem_empty,
    output logic [DATA_WIDTH-1:0] out
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Extra MSB on each pointer distinguishes full (wrap bits differ) from empty.
    assign mem_empty = (wptr == rptr);
    assign mem_full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                       (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    assign wr_accept = write_en && !mem_full;
    assign rd_accept = read_en && !mem_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            out  <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_accept) begin
                out  <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr <= rptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Randomized and directed bench for async_fifo against a queue-based reference model.
module tb_async_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          mem_full;
    logic          mem_empty;
    logic [DW-1:0] out;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_out = '0;

    async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .write_en  (write_en),
        .read_en   (read_en),
        .data_in   (data_in),
        .mem_full  (mem_full),
        .mem_empty (mem_empty),
        .out       (out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock with the given requests; the model decides acceptance from pre-edge occupancy.
    task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din);
        bit wa;
        bit ra;
        write_en = we;
        read_en  = re;
        data_in  = din;
        wa = we && (q.size() < DEPTH);
        ra = re && (q.size() > 0);
        @(posedge clk);
        if (ra) exp_out = q.pop_front();
        if (wa) q.push_back(din);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (mem_empty !== 1'b1 || mem_full !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: empty=%b full=%b out=%h, want empty=1 full=0 out=00",
                     mem_empty, mem_full, out);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (out !== 8'h00 || mem_empty !== 1'b1) begin
                errors++;
                $display("FAIL read_when_empty[%0d]: out=%h empty=%b, want out=00 empty=1",
                         i, out, mem_empty);
            end
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 1'b0, 8'h24);
        checks++;
        if (mem_empty !== 1'b0) begin
            errors++;
            $display("FAIL single_write_empty: empty=%b, want 0", mem_empty);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (out !== 8'h24 || mem_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_read: out=%h empty=%b, want out=24 empty=1", out, mem_empty);
        end
    endtask

    task automatic test_burst3();
        logic [DW-1:0] vals [3];
        vals[0] = 8'h81; vals[1] = 8'h09; vals[2] = 8'h63;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vals[i]);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (out !== vals[i]) begin
                errors++;
                $display("FAIL burst3_out[%0d]: got %h, want %h", i, out, vals[i]);
            end
        end
        checks++;
        if (mem_empty !== 1'b1) begin
            errors++;
            $display("FAIL burst3_empty: empty=%b, want 1", mem_empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, DW'(i));
            checks++;
            if (mem_full !== (i == DEPTH-1) || mem_empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_flags[%0d]: full=%b empty=%b, want full=%b empty=0",
                         i, mem_full, mem_empty, (i == DEPTH-1));
            end
        end
        cycle(1'b1, 1'b0, 8'hFF);
        checks++;
        if (mem_full !== 1'b1 || out !== exp_out) begin
            errors++;
            $display("FAIL write_when_full: full=%b out=%h, want full=1 out=%h",
                     mem_full, out, exp_out);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (out !== DW'(i) || mem_full !== 1'b0) begin
                errors++;
                $display("FAIL drain_out[%0d]: out=%h full=%b, want out=%h full=0",
                         i, out, mem_full, DW'(i));
            end
        end
        checks++;
        if (mem_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: empty=%b, want 1", mem_empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, DW'($urandom_range(0, 255)));
            checks++;
            if (out !== exp_out || mem_full !== 1'b0 || mem_empty !== 1'b0 || q.size() != 8) begin
                errors++;
                $display("FAIL b2b[%0d]: out=%h full=%b empty=%b, want out=%h full=0 empty=0 occ=8",
                         i, out, mem_full, mem_empty, exp_out);
            end
        end
        while (q.size() > 0) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL b2b_drain: out=%h, want %h", out, exp_out);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'hA0 + i));
        cycle(1'b0, 1'b1, 8'h00);
        #3;
        reset = 1'b1;
        #1;
        q.delete();
        exp_out = '0;
        checks++;
        if (mem_empty !== 1'b1 || mem_full !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: empty=%b full=%b out=%h, want empty=1 full=0 out=00",
                     mem_empty, mem_full, out);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (mem_empty !== 1'b1 || out !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_read: empty=%b out=%h, want empty=1 out=00", mem_empty, out);
        end
    endtask

    task automatic test_random();
        int wprob;
        for (int i = 0; i < 600; i++) begin
            // Alternate write-heavy and read-heavy phases to reach both full and empty.
            wprob = ((i / 60) % 2 == 0) ? 80 : 20;
            cycle($urandom_range(0, 99) < wprob, $urandom_range(0, 99) < (100 - wprob),
                  DW'($urandom_range(0, 255)));
            checks++;
            if (out !== exp_out || mem_empty !== (q.size() == 0) || mem_full !== (q.size() == DEPTH)) begin
                errors++;
                $display("FAIL random[%0d]: out=%h empty=%b full=%b, want out=%h empty=%b full=%b",
                         i, out, mem_empty, mem_full, exp_out, (q.size() == 0), (q.size() == DEPTH));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst3();
        test_fill();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
